serial_to_parallel_buffer: RTL and testbench



---
 rtl/serial_to_parallel_buffer.sv | 102 ++++++++++
 tb/tb_serial_to_parallel_buffer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_buffer.sv
// Purpose : collects WIDTH serial bits (one per enable strobe) into a word and queues it in a DEPTH-entry FIFO.
// Latency : a completed word is visible on data_out/valid the cycle after its last bit when the queue is empty.
// Backpres: consumer stalls via out_ready=0; a word completing into a full queue without a same-edge pop is dropped and overflow sticks.
//
// Ports:
//   clk, rst            - clock and asynchronous active-high reset
//   enable, data_in     - bit strobe and serial bit
//   clear               - synchronous discard of the partial word, also clears overflow
//   out_ready           - consumer accepts the head word
//   data_out, valid     - head-of-queue word (0 when empty) and queue non-empty flag
//   level, bit_count    - queued word count and bits in the partial word
//   overflow            - sticky word-dropped flag
module serial_to_parallel_buffer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      data_in,
  input  logic                      clear,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          data_out,
  output logic                      valid,
  output logic [$clog2(DEPTH):0]    level,
  output logic [$clog2(WIDTH)-1:0]  bit_count,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic complete;
  logic full;
  logic pop;
  logic push;
  logic ovf_set;

  // Shift register value including the bit sampled on this edge; this is
  // also the word written into the queue when the word completes.
  always_comb begin
    sr_next = sr;
    if (MSB_FIRST) sr_next = {sr[WIDTH-2:0], data_in};
    else           sr_next = {data_in, sr[WIDTH-1:1]};
  end

  assign complete = enable && !clear && (bit_count == CW'(WIDTH - 1));
  assign full     = (level == LW'(DEPTH));
  assign valid    = (level != '0);
  assign pop      = valid && out_ready;
  // A full queue still accepts a word when the head leaves on the same edge.
  assign push     = complete && (!full || pop);
  assign ovf_set  = complete && full && !pop;

  assign data_out = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr        <= '0;
      bit_count <= '0;
      overflow  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      if (clear) begin
        sr        <= '0;
        bit_count <= '0;
        overflow  <= 1'b0;
      end else if (enable) begin
        sr        <= sr_next;
        bit_count <= complete ? '0 : bit_count + 1'b1;
        if (ovf_set) overflow <= 1'b1;
      end

      // Pointers wrap naturally since DEPTH is a power of two; level keeps
      // full and empty distinct when the pointers are equal.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: valid gates data_out until a slot is written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sr_next;
  end

endmodule

// File: tb/tb_serial_to_parallel_buffer.sv
// Purpose : directed self-checking bench for serial_to_parallel_buffer (WIDTH=8, DEPTH=2).
// Latency : inputs driven on falling edges, outputs sampled on falling edges.
// Backpres: exercises out_ready stalls, overflow, and push/pop on a full queue.
module tb_serial_to_parallel_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       data_in;
  logic       clear;
  logic       out_ready;

  logic [7:0] data_out, data_out_l;
  logic       valid, valid_l;
  logic [1:0] level, level_l;
  logic [2:0] bit_count, bit_count_l;
  logic       overflow, overflow_l;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  serial_to_parallel_buffer #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in), .clear(clear),
    .out_ready(out_ready), .data_out(data_out), .valid(valid), .level(level),
    .bit_count(bit_count), .overflow(overflow)
  );

  serial_to_parallel_buffer #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in), .clear(clear),
    .out_ready(out_ready), .data_out(data_out_l), .valid(valid_l), .level(level_l),
    .bit_count(bit_count_l), .overflow(overflow_l)
  );

  task automatic drive_bit(input logic b);
    @(negedge clk);
    enable  = 1'b1;
    data_in = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      enable  = 1'b0;
      data_in = 1'b0;
    end
  endtask

  // Sends w starting with w[7].
  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) drive_bit(w[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; data_in = 1'b0; clear = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({valid, level, bit_count, overflow, data_out} !== 15'h0) begin
      fails++;
      $display("FAIL reset_state: got v=%b lvl=%0d bc=%0d ovf=%b dout=%h, want all 0",
               valid, level, bit_count, overflow, data_out);
    end
  endtask

  task automatic test_msb_first();
    do_reset();
    out_ready = 1'b1;
    send_word(8'hC2);
    idle(1);
    checks++;
    if ({valid, data_out} !== {1'b1, 8'hC2}) begin
      fails++;
      $display("FAIL msb_word: got v=%b dout=%h, want v=1 dout=c2", valid, data_out);
    end
    checks++;
    if ({bit_count, level} !== {3'd0, 2'd1}) begin
      fails++;
      $display("FAIL msb_counts: got bc=%0d lvl=%0d, want bc=0 lvl=1", bit_count, level);
    end
    idle(1);
    checks++;
    if ({valid, level, data_out} !== {1'b0, 2'd0, 8'h00}) begin
      fails++;
      $display("FAIL msb_drain: got v=%b lvl=%0d dout=%h, want v=0 lvl=0 dout=00",
               valid, level, data_out);
    end
  endtask

  task automatic test_lsb_first();
    do_reset();
    out_ready = 1'b1;
    send_word(8'hC2);
    idle(1);
    checks++;
    if ({valid_l, data_out_l} !== {1'b1, 8'h43}) begin
      fails++;
      $display("FAIL lsb_word: got v=%b dout=%h, want v=1 dout=43", valid_l, data_out_l);
    end
    idle(1);
    checks++;
    if ({valid_l, level_l} !== {1'b0, 2'd0}) begin
      fails++;
      $display("FAIL lsb_drain: got v=%b lvl=%0d, want v=0 lvl=0", valid_l, level_l);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] w;
    w = 8'hC2;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_bit(w[7-i]);
      idle(1);
      if (i < 7) begin
        checks++;
        if ({valid, bit_count} !== {1'b0, 3'(i + 1)}) begin
          fails++;
          $display("FAIL gap_bit%0d: got v=%b bc=%0d, want v=0 bc=%0d", i, valid, bit_count, i + 1);
        end
        idle(2);
        checks++;
        if ({valid, bit_count} !== {1'b0, 3'(i + 1)}) begin
          fails++;
          $display("FAIL gap_hold%0d: got v=%b bc=%0d, want v=0 bc=%0d", i, valid, bit_count, i + 1);
        end
      end else begin
        checks++;
        if ({valid, data_out, bit_count} !== {1'b1, 8'hC2, 3'd0}) begin
          fails++;
          $display("FAIL gap_word: got v=%b dout=%h bc=%0d, want v=1 dout=c2 bc=0",
                   valid, data_out, bit_count);
        end
        idle(2);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    idle(1);
    checks++;
    if ({level, overflow, valid, data_out} !== {2'd2, 1'b1, 1'b1, 8'h11}) begin
      fails++;
      $display("FAIL ovf_full: got lvl=%0d ovf=%b v=%b dout=%h, want lvl=2 ovf=1 v=1 dout=11",
               level, overflow, valid, data_out);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({level, data_out} !== {2'd1, 8'h22}) begin
      fails++;
      $display("FAIL ovf_pop1: got lvl=%0d dout=%h, want lvl=1 dout=22", level, data_out);
    end
    @(negedge clk);
    checks++;
    if ({valid, level, overflow, data_out} !== {1'b0, 2'd0, 1'b1, 8'h00}) begin
      fails++;
      $display("FAIL ovf_pop2: got v=%b lvl=%0d ovf=%b dout=%h, want v=0 lvl=0 ovf=1 dout=00",
               valid, level, overflow, data_out);
    end
    out_ready = 1'b0;
    clear     = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: got ovf=%b, want 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    w = 8'h33;
    do_reset();
    out_ready = 1'b0;
    send_word(8'h11);
    send_word(8'h22);
    for (int i = 7; i >= 1; i--) drive_bit(w[i]);
    drive_bit(w[0]);
    out_ready = 1'b1;
    idle(1);
    checks++;
    if ({level, overflow, data_out} !== {2'd2, 1'b0, 8'h22}) begin
      fails++;
      $display("FAIL b2b_full: got lvl=%0d ovf=%b dout=%h, want lvl=2 ovf=0 dout=22",
               level, overflow, data_out);
    end
    @(negedge clk);
    checks++;
    if ({level, data_out} !== {2'd1, 8'h33}) begin
      fails++;
      $display("FAIL b2b_pop: got lvl=%0d dout=%h, want lvl=1 dout=33", level, data_out);
    end
    @(negedge clk);
    checks++;
    if ({valid, level} !== {1'b0, 2'd0}) begin
      fails++;
      $display("FAIL b2b_empty: got v=%b lvl=%0d, want v=0 lvl=0", valid, level);
    end
  endtask

  task automatic test_clear();
    do_reset();
    out_ready = 1'b1;
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0);
    idle(1);
    checks++;
    if (bit_count !== 3'd5) begin
      fails++;
      $display("FAIL clr_pre: got bc=%0d, want 5", bit_count);
    end
    // clear wins over a simultaneous strobe
    @(negedge clk);
    clear = 1'b1; enable = 1'b1; data_in = 1'b1;
    @(negedge clk);
    clear = 1'b0; enable = 1'b0;
    checks++;
    if ({bit_count, valid} !== {3'd0, 1'b0}) begin
      fails++;
      $display("FAIL clr_bc: got bc=%0d v=%b, want bc=0 v=0", bit_count, valid);
    end
    send_word(8'hA5);
    idle(1);
    checks++;
    if ({valid, data_out} !== {1'b1, 8'hA5}) begin
      fails++;
      $display("FAIL clr_word: got v=%b dout=%h, want v=1 dout=a5", valid, data_out);
    end
    idle(1);
    // clear on the completing edge suppresses the push
    for (int i = 0; i < 7; i++) drive_bit(1'b1);
    @(negedge clk);
    clear = 1'b1; enable = 1'b1; data_in = 1'b1;
    @(negedge clk);
    clear = 1'b0; enable = 1'b0;
    checks++;
    if ({valid, level, bit_count} !== {1'b0, 2'd0, 3'd0}) begin
      fails++;
      $display("FAIL clr_complete: got v=%b lvl=%0d bc=%0d, want all 0", valid, level, bit_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    idle(1);
    checks++;
    if ({bit_count, level, overflow} !== {3'd3, 2'd2, 1'b1}) begin
      fails++;
      $display("FAIL arst_pre: got bc=%0d lvl=%0d ovf=%b, want bc=3 lvl=2 ovf=1",
               bit_count, level, overflow);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bit_count, valid, level, overflow, data_out} !== 15'h0) begin
      fails++;
      $display("FAIL arst_now: got bc=%0d v=%b lvl=%0d ovf=%b dout=%h, want all 0",
               bit_count, valid, level, overflow, data_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0; data_in = 1'b0; clear = 1'b0; out_ready = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_gapped();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
